// File: rtl/bcd_to_signed_bin_pkg.sv
// Shared constants for the BCD-to-signed-binary converter.
// Holds state encodings, widths, saturation values and the digit validity helper.
package bcd_to_signed_bin_pkg;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int OUT_W  = 8;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    localparam logic [3:0]       BCD_MAX     = 4'd9;
    localparam logic [OUT_W-1:0] SAT_POS     = 8'h7F;
    localparam logic [OUT_W-1:0] SAT_NEG     = 8'h80;
    localparam logic [BIN_W-1:0] MAG_POS_MAX = 10'd127;
    localparam logic [BIN_W-1:0] MAG_NEG_MAX = 10'd128;
    localparam logic [CNT_W-1:0] LAST_STEP   = 4'd9;

    // True when any 4-bit group holds a non-decimal code.
    function automatic logic digits_invalid(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_rshift_step.sv
// One combinational step of reverse double-dabble: shift {bcd,mag} right,
// then correct every BCD group that landed at 8 or above by subtracting 3.
module bcd_rshift_step
    import bcd_to_signed_bin_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [BIN_W-1:0] mag_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic [BIN_W-1:0] mag_out
);

    logic [BCD_W-1:0] bcd_sh_s;

    // Shift then per-digit correction
    always_comb begin
        {bcd_sh_s, mag_out} = {1'b0, bcd_in, mag_in[BIN_W-1:1]};
        bcd_out = bcd_sh_s;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh_s[4*i +: 4] >= 4'd8) begin
                bcd_out[4*i +: 4] = bcd_sh_s[4*i +: 4] - 4'd3;
            end else begin
                bcd_out[4*i +: 4] = bcd_sh_s[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/bcd_to_signed_bin.sv
// Sequential sign/magnitude BCD to 8-bit two's-complement converter.
// One reverse double-dabble step per clock, start/done handshake, saturating range check.
module bcd_to_signed_bin
    import bcd_to_signed_bin_pkg::*;
(
    input  logic             CLK100MHZ,
    input  logic             RST_N,
    input  logic             start,
    input  logic             sign,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             err_digit,
    output logic             err_range
);

    logic [1:0]       state_r;
    logic [BCD_W-1:0] bcd_sr_r;
    logic [BIN_W-1:0] mag_r;
    logic             sign_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [OUT_W-1:0] result_r;
    logic             err_digit_r;
    logic             err_range_r;

    logic [BCD_W-1:0] bcd_in_s;
    logic [BCD_W-1:0] bcd_nxt_s;
    logic [BIN_W-1:0] mag_nxt_s;
    logic [OUT_W-1:0] result_fin_s;
    logic             err_range_fin_s;

    assign bcd_in_s = {hundreds, tens, ones};

    bcd_rshift_step u_step (
        .bcd_in  (bcd_sr_r),
        .mag_in  (mag_r),
        .bcd_out (bcd_nxt_s),
        .mag_out (mag_nxt_s)
    );

    // Sign application with saturation; zero magnitude never yields a negative zero
    always_comb begin
        result_fin_s    = 8'h00;
        err_range_fin_s = 1'b0;
        if (sign_r) begin
            if (mag_r <= MAG_NEG_MAX) begin
                result_fin_s    = 8'h00 - mag_r[OUT_W-1:0];
                err_range_fin_s = 1'b0;
            end else begin
                result_fin_s    = SAT_NEG;
                err_range_fin_s = 1'b1;
            end
        end else begin
            if (mag_r <= MAG_POS_MAX) begin
                result_fin_s    = mag_r[OUT_W-1:0];
                err_range_fin_s = 1'b0;
            end else begin
                result_fin_s    = SAT_POS;
                err_range_fin_s = 1'b1;
            end
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge CLK100MHZ) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            bcd_sr_r    <= {BCD_W{1'b0}};
            mag_r       <= {BIN_W{1'b0}};
            sign_r      <= 1'b0;
            step_cnt_r  <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {OUT_W{1'b0}};
            err_digit_r <= 1'b0;
            err_range_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        bcd_sr_r   <= bcd_in_s;
                        sign_r     <= sign;
                        mag_r      <= {BIN_W{1'b0}};
                        step_cnt_r <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= digits_invalid(bcd_in_s) ? ST_ERR : ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    bcd_sr_r   <= bcd_nxt_s;
                    mag_r      <= mag_nxt_s;
                    step_cnt_r <= step_cnt_r + 4'd1;
                    if (step_cnt_r == LAST_STEP) begin
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_FINISH: begin
                    done_r      <= 1'b1;
                    result_r    <= result_fin_s;
                    err_digit_r <= 1'b0;
                    err_range_r <= err_range_fin_s;
                    state_r     <= ST_IDLE;
                end
                ST_ERR: begin
                    done_r      <= 1'b1;
                    result_r    <= {OUT_W{1'b0}};
                    err_digit_r <= 1'b1;
                    err_range_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign err_digit = err_digit_r;
    assign err_range = err_range_r;

endmodule

// File: tb/tb_bcd_to_signed_bin.sv
// Self-checking bench for bcd_to_signed_bin: directed cases plus random entries,
// compared against a decimal-arithmetic reference model.
module tb_bcd_to_signed_bin;

    logic       CLK100MHZ = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err_digit;
    logic       err_range;

    int pass_cnt = 0;
    int total_cnt = 0;

    bcd_to_signed_bin dut (
        .CLK100MHZ (CLK100MHZ),
        .RST_N     (RST_N),
        .start     (start),
        .sign      (sign),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err_digit (err_digit),
        .err_range (err_range)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference: decimal value from digits, then signed saturation to 8 bits
    task automatic model(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         output logic [7:0] res, output logic ed, output logic er);
        int val;
        int sv;
        ed = 1'b0;
        er = 1'b0;
        res = 8'h00;
        if (h > 9 || t > 9 || o > 9) begin
            ed = 1'b1;
        end else begin
            val = h * 100 + t * 10 + o;
            sv = s ? -val : val;
            if (sv > 127) begin
                res = 8'h7F;
                er = 1'b1;
            end else if (sv < -128) begin
                res = 8'h80;
                er = 1'b1;
            end else begin
                res = sv[7:0];
            end
        end
    endtask

    // Wait at negedges for done, bounded; optionally pulse start with junk digits mid-shift
    task automatic wait_done(input bit glitch, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge CLK100MHZ);
            lat++;
            if (glitch && lat == 3) begin
                start = 1'b1;
                sign = ~sign;
                hundreds = 4'($urandom_range(0, 15));
                tens = 4'($urandom_range(0, 15));
                ones = 4'($urandom_range(0, 15));
            end
            if (glitch && lat == 4) start = 1'b0;
        end
    endtask

    task automatic run_conv(input logic s, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input bit glitch);
        logic [7:0] er_res;
        logic ed, er;
        int lat;
        model(s, h, t, o, er_res, ed, er);
        @(negedge CLK100MHZ);
        sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
        @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        start = 1'b0;
        check_val("busy_after_accept", busy, 1);
        wait_done(glitch, lat);
        check_val("latency", lat, ed ? 1 : 11);
        check_val("result", result, er_res);
        check_val("err_digit", err_digit, ed);
        check_val("err_range", err_range, er);
        check_val("busy_in_done", busy, 1);
        @(negedge CLK100MHZ);
        check_val("done_one_cycle", done, 0);
        check_val("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [7:0] er_res;
        logic ed, er;
        logic [7:0] held_res;
        int lat;
        int done_seen;

        repeat (3) @(negedge CLK100MHZ);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_result", result, 0);
        check_val("rst_errs", {err_digit, err_range}, 0);
        RST_N = 1'b1;

        run_conv(1'b0, 4'd1, 4'd2, 4'd7, 1'b0);
        run_conv(1'b1, 4'd1, 4'd2, 4'd8, 1'b0);
        run_conv(1'b1, 4'd0, 4'd0, 4'd5, 1'b0);
        run_conv(1'b0, 4'd1, 4'd2, 4'd8, 1'b0);
        run_conv(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
        run_conv(1'b0, 4'd0, 4'hA, 4'd3, 1'b0);
        run_conv(1'b0, 4'd0, 4'd4, 4'd2, 1'b1);
        run_conv(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
        run_conv(1'b1, 4'd1, 4'd2, 4'd9, 1'b0);

        // Reset during the fifth shift step aborts without a done pulse
        @(negedge CLK100MHZ);
        sign = 1'b0; hundreds = 4'd0; tens = 4'd9; ones = 4'd9; start = 1'b1;
        @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        start = 1'b0;
        repeat (4) @(negedge CLK100MHZ);
        RST_N = 1'b0;
        @(negedge CLK100MHZ);
        RST_N = 1'b1;
        check_val("abort_busy", busy, 0);
        check_val("abort_result", result, 0);
        check_val("abort_errs", {err_digit, err_range}, 0);
        done_seen = 0;
        repeat (15) begin
            @(negedge CLK100MHZ);
            if (done === 1'b1) done_seen++;
        end
        check_val("abort_no_done", done_seen, 0);
        run_conv(1'b0, 4'd0, 4'd6, 4'd4, 1'b0);

        // start held through done: next conversion accepted right after the done cycle
        @(negedge CLK100MHZ);
        sign = 1'b0; hundreds = 4'd0; tens = 4'd3; ones = 4'd3; start = 1'b1;
        @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        wait_done(1'b0, lat);
        check_val("b2b_first_lat", lat, 11);
        check_val("b2b_first_res", result, 8'd33);
        held_res = result;
        sign = 1'b1; hundreds = 4'd0; tens = 4'd7; ones = 4'd7;
        @(negedge CLK100MHZ);
        start = 1'b0;
        check_val("b2b_busy", busy, 1);
        check_val("b2b_done_low", done, 0);
        check_val("b2b_held", result, held_res);
        wait_done(1'b0, lat);
        check_val("b2b_second_lat", lat, 11);
        check_val("b2b_second_res", result, 8'hB3);
        @(negedge CLK100MHZ);

        // Random entries, mostly valid digits with occasional bad codes
        for (int i = 0; i < 40; i++) begin
            logic s;
            logic [3:0] h, t, o;
            s = 1'($urandom_range(0, 1));
            h = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
            t = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
            o = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
            if (i < 20) h = 4'($urandom_range(0, 1));
            run_conv(s, h, t, o, 1'($urandom_range(0, 3) == 0));
        end

        model(1'b1, 4'd1, 4'd2, 4'd8, er_res, ed, er);
        run_conv(1'b1, 4'd1, 4'd2, 4'd8, 1'b0);
        check_val("final_neg128", result, er_res);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
